serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder/subtractor. One full-adder cell
// and a carry flip-flop work through the operands one bit per clock, LSB
// first.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request; sampled only while idle
//   sub    0: X+Y+Cin   1: X-Y-Cin (Cin acts as borrow-in)
//   X, Y   operands, latched together with start
//   Cin    carry-in / borrow-in, latched together with start
//   Sum    registered result
//   Cout   final carry-out; in subtract mode 1 means no borrow
//   Ovf    two's-complement overflow
//   busy   high while bits are being processed
//   done   one-cycle completion pulse
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  // The single full-adder cell.
  logic s_bit;
  logic c_next;

  always_comb begin
    s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
    c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is X + ~Y + 1. A borrow-in removes that +1,
            // so the initial carry is Cin ^ sub.
            a_sr  <= X;
            b_sr  <= sub ? ~Y : Y;
            carry <= Cin ^ sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          r_sr  <= {s_bit, r_sr[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= c_next;
          if (cnt == LAST) begin
            // This edge processes the MSB. The carry FF still holds the
            // carry into the MSB, so overflow is that carry XOR the carry-out.
            Sum   <= {s_bit, r_sr[WIDTH-1:1]};
            Cout  <= c_next;
            Ovf   <= carry ^ c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder. One instance uses WIDTH=8 for the
// scenario tests. A second instance uses WIDTH=2 for an exhaustive sweep.
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       start8, sub8, cin8;
  logic [7:0] x8, y8;
  logic [7:0] sum8;
  logic       cout8, ovf8, busy8, done8;

  logic       start2, sub2, cin2;
  logic [1:0] x2, y2;
  logic [1:0] sum2;
  logic       cout2, ovf2, busy2, done2;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .X(x8), .Y(y8),
    .Cin(cin8), .Sum(sum8), .Cout(cout8), .Ovf(ovf8), .busy(busy8),
    .done(done8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .X(x2), .Y(y2),
    .Cin(cin2), .Sum(sum2), .Cout(cout2), .Ovf(ovf2), .busy(busy2),
    .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs are sampled on the falling edge.
  // Sample n is taken after rising edge n-1, where edge 0 samples start.
  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      input logic ci, input logic sb,
                      output logic [7:0] s, output logic co, output logic ov,
                      output int busy_n, output int done_at,
                      output logic done_clr, output logic timeout);
    @(negedge clk);
    x8 = x; y8 = y; cin8 = ci; sub8 = sb; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_n = 0; done_at = 0; timeout = 1'b1;
    s = '0; co = 1'b0; ov = 1'b0; done_clr = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (busy8) busy_n++;
      if (done8) begin
        done_at = n; timeout = 1'b0;
        s = sum8; co = cout8; ov = ovf8;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    done_clr = !done8;
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 1'b1; start2 = 1'b1;
    x8 = 8'hAA; y8 = 8'h55; cin8 = 1'b1; sub8 = 1'b0;
    x2 = 2'b11; y2 = 2'b01; cin2 = 1'b1; sub2 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000) begin
        errors++;
        $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b busy=%b done=%b, want all zero",
                 sum8, cout8, ovf8, busy8, done8);
      end
    end
    rst = 1'b0; start8 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_start: got busy8=%b busy2=%b, want 0", busy8, busy2);
    end
  endtask

  task automatic test_add;
    logic [7:0] s; logic co, ov, clr, to; int bn, da;
    run8(8'h5A, 8'h3C, 1'b0, 1'b0, s, co, ov, bn, da, clr, to);
    checks++;
    if (to) begin
      errors++; $display("FAIL add_timeout: no done within 30 cycles");
    end
    checks++;
    if (bn != 8 || da != 9) begin
      errors++;
      $display("FAIL add_latency: got busy_cycles=%0d done_at=%0d, want 8 and 9", bn, da);
    end
    checks++;
    if ({s, co, ov} !== {8'h96, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_result: got sum=%h cout=%b ovf=%b, want 96 0 1", s, co, ov);
    end
    checks++;
    if (!clr) begin
      errors++; $display("FAIL add_done_pulse: got done high two cycles, want one");
    end

    run8(8'hFF, 8'h01, 1'b1, 1'b0, s, co, ov, bn, da, clr, to);
    checks++;
    if (to || {s, co, ov} !== {8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_carry: got sum=%h cout=%b ovf=%b timeout=%b, want 01 1 0", s, co, ov, to);
    end
  endtask

  task automatic test_sub;
    logic [7:0] s; logic co, ov, clr, to; int bn, da;
    run8(8'h10, 8'h20, 1'b0, 1'b1, s, co, ov, bn, da, clr, to);
    checks++;
    if (to || {s, co, ov} !== {8'hF0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow: got sum=%h cout=%b ovf=%b timeout=%b, want f0 0 0", s, co, ov, to);
    end
    run8(8'h80, 8'h01, 1'b0, 1'b1, s, co, ov, bn, da, clr, to);
    checks++;
    if (to || {s, co, ov} !== {8'h7F, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_overflow: got sum=%h cout=%b ovf=%b timeout=%b, want 7f 1 1", s, co, ov, to);
    end
  endtask

  // A start pulse during RUN must be dropped. Sum must hold the previous
  // result (7f) until the running operation completes.
  task automatic test_ignored_start;
    int dones; logic held; logic [7:0] got;
    dones = 0; held = 1'b1; got = 8'h00;
    @(negedge clk);
    x8 = 8'h01; y8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int n = 1; n <= 22; n++) begin
      if (done8) begin
        dones++; got = sum8;
      end else if (dones == 0 && sum8 !== 8'h7F) begin
        held = 1'b0;
      end
      if (n == 4) begin
        x8 = 8'hFF; y8 = 8'hFF; start8 = 1'b1;
      end
      if (n == 5) start8 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL ignored_start_pulses: got %0d done pulses, want 1", dones);
    end
    checks++;
    if (got !== 8'h02) begin
      errors++; $display("FAIL ignored_start_result: got sum=%h, want 02", got);
    end
    checks++;
    if (!held) begin
      errors++; $display("FAIL ignored_start_hold: sum changed before done, want 7f held");
    end
  endtask

  task automatic test_reset_mid_op;
    logic [7:0] s; logic co, ov, clr, to; int bn, da; int dones;
    dones = 0;
    @(negedge clk);
    x8 = 8'h11; y8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || sum8 !== 8'h00 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: got busy=%b sum=%h done=%b, want 0 00 0", busy8, sum8, done8);
    end
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL reset_mid_op_done: got %0d done pulses, want 0", dones);
    end
    run8(8'h03, 8'h04, 1'b0, 1'b0, s, co, ov, bn, da, clr, to);
    checks++;
    if (to || {s, co, ov} !== {8'h07, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL restart_after_reset: got sum=%h cout=%b ovf=%b timeout=%b, want 07 0 0", s, co, ov, to);
    end
  endtask

  // Full sweep at WIDTH=2. Overflow is checked with the sign rule: operands
  // of equal sign giving a result of the other sign.
  task automatic test_exhaustive_w2;
    logic [1:0] yb, es; logic c0, ec, eo; int tot; logic seen;
    for (int v = 0; v < 64; v++) begin
      @(negedge clk);
      x2 = v[1:0]; y2 = v[3:2]; cin2 = v[4]; sub2 = v[5]; start2 = 1'b1;
      yb = sub2 ? ~y2 : y2;
      c0 = cin2 ^ sub2;
      tot = int'(x2) + int'(yb) + int'(c0);
      es = tot[1:0];
      ec = tot[2];
      eo = (x2[1] == yb[1]) && (es[1] != x2[1]);
      @(negedge clk);
      start2 = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        if (done2) seen = 1'b1;
        else @(negedge clk);
      end
      checks++;
      if (!seen || {sum2, cout2, ovf2} !== {es, ec, eo}) begin
        errors++;
        $display("FAIL w2 x=%0d y=%0d cin=%b sub=%b: got sum=%0d cout=%b ovf=%b done=%b, want %0d %b %b",
                 x2, y2, cin2, sub2, sum2, cout2, ovf2, seen, es, ec, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignored_start();
    test_reset_mid_op();
    test_exhaustive_w2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
